// File: rtl/banco_pkg.sv
// Shared types and helpers for the multiport register bank.
// The legality check is common to the write decode and to every read port.
package banco_pkg;

    typedef enum logic {
        OCIOSO   = 1'b0,
        LIMPANDO = 1'b1
    } estado_t;

    localparam int LARGURA_PADRAO      = 16;
    localparam int PROFUNDIDADE_PADRAO = 16;

    // An address is legal if it is in range and not the hard-wired zero register.
    function automatic logic valido(input logic [31:0] addr,
                                    input logic [31:0] prof,
                                    input logic        zero_r0);
        return (addr < prof) && !(zero_r0 && (addr == 32'd0));
    endfunction

endpackage

// File: rtl/banco_registradores_multiporta_porta_leitura.sv
// One registered read port: address decode, write-first bypass and sweep bypass.
// The captured value is what the addressed register holds after the same edge.
module porta_leitura
    import banco_pkg::*;
#(
    parameter int LARGURA      = LARGURA_PADRAO,
    parameter int PROFUNDIDADE = PROFUNDIDADE_PADRAO,
    parameter int ZERO_R0      = 0,
    parameter int AW           = $clog2(PROFUNDIDADE)
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [AW-1:0]                          end_leitura_i,
    input  logic [PROFUNDIDADE-1:0][LARGURA-1:0]   mem_i,
    input  logic                                   we_i,
    input  logic [AW-1:0]                          end_escrita_i,
    input  logic [LARGURA-1:0]                     dado_i,
    input  logic                                   limpando_i,
    input  logic [AW-1:0]                          idx_i,
    output logic [LARGURA-1:0]                     saida_o
);

    logic [LARGURA-1:0] saida_d;
    logic [LARGURA-1:0] saida_q;

    always_comb begin
        saida_d = '0;
        for (int i = 0; i < PROFUNDIDADE; i++) begin
            if (end_leitura_i == AW'(i)) saida_d = mem_i[i];
        end
        // Priority mirrors the storage update: sweep clears, an external write wins.
        if (limpando_i && (end_leitura_i == idx_i)) saida_d = '0;
        if (we_i && (end_escrita_i == end_leitura_i)) saida_d = dado_i;
        if (!valido(32'(end_leitura_i), 32'(PROFUNDIDADE), ZERO_R0 != 0)) saida_d = '0;
    end

    always_ff @(posedge clk) begin
        if (!reset) saida_q <= '0;
        else        saida_q <= saida_d;
    end

    assign saida_o = saida_q;

endmodule

// File: rtl/banco_registradores_multiporta.sv
// Parameterised register file with NLEITURA bypassed read ports and a
// sequential clear engine that zeroes one register per cycle.
module banco_registradores_multiporta
    import banco_pkg::*;
#(
    parameter int LARGURA      = LARGURA_PADRAO,
    parameter int PROFUNDIDADE = PROFUNDIDADE_PADRAO,
    parameter int NLEITURA     = 3,
    parameter int ZERO_R0      = 0,
    localparam int AW          = $clog2(PROFUNDIDADE)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         sinal,
    input  logic [AW-1:0]                end_escrita,
    input  logic [LARGURA-1:0]           dado,
    input  logic [NLEITURA*AW-1:0]       end_leitura,
    output logic [NLEITURA*LARGURA-1:0]  saida,
    input  logic                         limpar,
    output logic                         ocupado,
    output logic                         pronto
);

    logic [PROFUNDIDADE-1:0][LARGURA-1:0] mem_q, mem_d;
    estado_t                              estado_q;
    logic [AW-1:0]                        idx_q;
    logic                                 pronto_q;
    logic                                 we;
    logic                                 limpando;

    assign we       = sinal && valido(32'(end_escrita), 32'(PROFUNDIDADE), ZERO_R0 != 0);
    assign limpando = (estado_q == LIMPANDO);

    always_comb begin
        mem_d = mem_q;
        for (int i = 0; i < PROFUNDIDADE; i++) begin
            if (limpando && (idx_q == AW'(i)))    mem_d[i] = '0;
            if (we && (end_escrita == AW'(i)))    mem_d[i] = dado;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) mem_q <= '0;
        else        mem_q <= mem_d;
    end

    // Clear engine: idx walks 0..PROFUNDIDADE-1, pronto pulses on the last edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            estado_q <= OCIOSO;
            idx_q    <= '0;
            pronto_q <= 1'b0;
        end else begin
            pronto_q <= 1'b0;
            case (estado_q)
                OCIOSO: begin
                    if (limpar) begin
                        estado_q <= LIMPANDO;
                        idx_q    <= '0;
                    end
                end
                LIMPANDO: begin
                    if (idx_q == AW'(PROFUNDIDADE - 1)) begin
                        estado_q <= OCIOSO;
                        pronto_q <= 1'b1;
                    end else begin
                        idx_q <= idx_q + AW'(1);
                    end
                end
                default: estado_q <= OCIOSO;
            endcase
        end
    end

    assign ocupado = limpando;
    assign pronto  = pronto_q;

    for (genvar k = 0; k < NLEITURA; k++) begin : g_porta
        porta_leitura #(
            .LARGURA     (LARGURA),
            .PROFUNDIDADE(PROFUNDIDADE),
            .ZERO_R0     (ZERO_R0),
            .AW          (AW)
        ) u_porta (
            .clk          (clk),
            .reset        (reset),
            .end_leitura_i(end_leitura[k*AW +: AW]),
            .mem_i        (mem_q),
            .we_i         (we),
            .end_escrita_i(end_escrita),
            .dado_i       (dado),
            .limpando_i   (limpando),
            .idx_i        (idx_q),
            .saida_o      (saida[k*LARGURA +: LARGURA])
        );
    end

endmodule

// File: tb/tb_banco_registradores_multiporta.sv
// Scoreboard bench: the driver pushes expected post-edge outputs from an
// array-based model; a monitor pops and compares after every rising edge.
module tb_banco_registradores_multiporta;

    localparam int W  = 16;
    localparam int P  = 12;
    localparam int NL = 3;
    localparam int AW = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              sinal;
    logic [AW-1:0]     end_escrita;
    logic [W-1:0]      dado;
    logic [NL*AW-1:0]  end_leitura;
    logic [NL*W-1:0]   saida;
    logic              limpar;
    logic              ocupado;
    logic              pronto;

    banco_registradores_multiporta #(
        .LARGURA(W), .PROFUNDIDADE(P), .NLEITURA(NL), .ZERO_R0(1)
    ) dut (
        .clk(clk), .reset(reset), .sinal(sinal), .end_escrita(end_escrita),
        .dado(dado), .end_leitura(end_leitura), .saida(saida),
        .limpar(limpar), .ocupado(ocupado), .pronto(pronto)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NL*W-1:0] s;
        logic            oc;
        logic            pr;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model: register contents plus sweep position.
    logic [W-1:0] m_mem [P];
    bit           m_sw  = 0;
    int           m_pos = 0;
    bit           m_pr  = 0;

    task automatic step(input bit r, input bit we, input int wa, input logic [W-1:0] wd,
                        input int ra0, input int ra1, input int ra2, input bit cl);
        exp_t e;
        int   ra [NL];
        @(negedge clk);
        reset       = r;
        sinal       = we;
        end_escrita = AW'(wa);
        dado        = wd;
        end_leitura = {AW'(ra2), AW'(ra1), AW'(ra0)};
        limpar      = cl;
        ra[0] = ra0; ra[1] = ra1; ra[2] = ra2;
        if (!r) begin
            foreach (m_mem[i]) m_mem[i] = '0;
            m_sw = 0; m_pos = 0; m_pr = 0;
        end else begin
            if (m_sw) m_mem[m_pos] = '0;
            if (we && wa < P && wa != 0) m_mem[wa] = wd;
            m_pr = 0;
            if (m_sw) begin
                if (m_pos == P - 1) begin m_sw = 0; m_pr = 1; end
                else m_pos++;
            end else if (cl) begin
                m_sw = 1; m_pos = 0;
            end
        end
        e.s = '0;
        for (int k = 0; k < NL; k++)
            e.s[k*W +: W] = (ra[k] < P && ra[k] != 0) ? m_mem[ra[k]] : '0;
        e.oc = m_sw;
        e.pr = m_pr;
        q.push_back(e);
    endtask

    task automatic idle_read(input int a0, input int a1, input int a2);
        step(1, 0, 0, '0, a0, a1, a2, 0);
    endtask

    // Monitor: outputs are valid every cycle, compared once per edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                for (int k = 0; k < NL; k++) begin
                    n_cmp++;
                    if (saida[k*W +: W] !== e.s[k*W +: W]) begin
                        n_err++;
                        $display("FAIL saida[%0d] t=%0t got=%h exp=%h", k, $time, saida[k*W +: W], e.s[k*W +: W]);
                    end
                end
                n_cmp++;
                if (ocupado !== e.oc) begin
                    n_err++;
                    $display("FAIL ocupado t=%0t got=%b exp=%b", $time, ocupado, e.oc);
                end
                n_cmp++;
                if (pronto !== e.pr) begin
                    n_err++;
                    $display("FAIL pronto t=%0t got=%b exp=%b", $time, pronto, e.pr);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog t=%0t got=timeout exp=finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        foreach (m_mem[i]) m_mem[i] = '0;
        reset = 0; sinal = 0; end_escrita = '0; dado = '0; end_leitura = '0; limpar = 0;

        // Reset then read
        step(0, 0, 0, '0, 0, 0, 0, 0);
        step(1, 1, 5, 16'hBEEF, 5, 5, 5, 0);
        idle_read(5, 1, 2);
        step(0, 0, 0, '0, 5, 5, 5, 0);
        idle_read(5, 5, 5);

        // Bypass on all ports, ZERO_R0, out-of-range write and read
        step(1, 1, 7, 16'h1234, 7, 7, 7, 0);
        step(1, 1, 0, 16'hFFFF, 0, 0, 7, 0);
        idle_read(0, 0, 0);
        step(1, 1, 13, 16'hABCD, 13, 13, 7, 0);
        idle_read(13, 12, 15);

        // Preload, sweep with races against the current index
        for (int i = 1; i < P; i++) step(1, 1, i, 16'h00A0 + 16'(i), i, 11, 0, 0);
        step(1, 0, 0, '0, 11, 11, 11, 1);
        for (int j = 0; j < P + 2; j++) begin
            if (m_pos == 4 && m_sw)      step(1, 1, m_pos,     16'h5555, m_pos, 11, m_pos + 3, 0);
            else if (m_pos == 5 && m_sw) step(1, 1, m_pos + 3, 16'h6666, 8, 11, 4, 0);
            else if (m_pos == 7 && m_sw) step(1, 1, m_pos - 1, 16'h7777, 6, 11, 4, 0);
            else                         step(1, 0, 0, '0, m_pos, 11, 8, 1);
        end
        for (int a = 0; a < P; a += 3) idle_read(a, a + 1, a + 2);

        // Abort mid-sweep with reset
        for (int i = 1; i < P; i++) step(1, 1, i, 16'(i * 17), i, 0, 0, 0);
        step(1, 0, 0, '0, 3, 4, 5, 1);
        for (int j = 0; j < 4; j++) idle_read(3, 4, 5);
        step(0, 0, 0, '0, 3, 4, 5, 0);
        for (int j = 0; j < P + 2; j++) idle_read(j % P, 6, 11);

        // Randomised traffic
        for (int n = 0; n < 3000; n++) begin
            bit r, we, cl;
            int wa, r0, r1, r2;
            r  = ($urandom_range(0, 99) != 0);
            we = $urandom_range(0, 1);
            wa = $urandom_range(0, 15);
            r0 = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, 15);
            r1 = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, 15);
            r2 = ($urandom_range(0, 3) == 0) ? m_pos : $urandom_range(0, 15);
            cl = ($urandom_range(0, 19) == 0);
            step(r, we, wa, 16'($urandom), r0, r1, r2, cl);
        end

        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain got=%0d pending exp=0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
